// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the sequential multiplier
// Purpose : FSM state encoding and default operand width used by seq_mult_core
//           and shift_add_datapath.
// Ports   : none (package)
// Config  : SIGNED_MULT_EN (consumed by seq_mult_core, nothing here depends on it)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - shift-add accumulator and iteration counter
// Purpose : holds the 2*WIDTH accumulator, performs one conditional add plus
//           right shift per step and counts iterations.
// Ports   : clk, rst (async active-low)
//           load      - initialise acc={0,b}, cnt=0
//           step      - perform one add/shift iteration, cnt++
//           a         - multiplicand (magnitude) added into the upper half
//           b         - multiplier (magnitude) loaded into the lower half
//           acc       - accumulator, final product after WIDTH steps
//           last_iter - high while the step in progress is the final one
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last_iter
);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;

  // Upper half plus A when the current multiplier bit is set; the extra bit
  // keeps the carry so it can be shifted back into the MSB.
  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a : {WIDTH{1'b0}})};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, b};
      cnt <= '0;
    end else if (step) begin
      acc <= {sum, acc[WIDTH-1:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// rtl/seq_mult_core.sv - shift-add sequential multiplier with start/done handshake
// Purpose : accepts a Start pulse, runs WIDTH shift-add iterations and answers
//           with a one-cycle Done pulse and a held Product.
// Ports   : clk          - rising-edge clock
//           rst          - asynchronous active-low reset
//           Start        - start request, honoured only in IDLE
//           Multiplicand - operand A, sampled on accepted Start
//           Multiplier   - operand B, sampled on accepted Start
//           Product      - 2*WIDTH result, updated with Done, held otherwise
//           Busy         - high while an operation is in progress
//           Done         - one-cycle completion pulse
// Config  : SIGNED_MULT_EN - two's complement operands (magnitude loop plus
//           sign fix-up at completion); undefined gives a purely unsigned core.
module seq_mult_core
  import mult_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  mult_state_t        state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result;
  logic               last_iter;
  logic               load;
  logic               step;

  assign load = (state == IDLE) && Start;
  assign step = (state == RUN);

`ifdef SIGNED_MULT_EN
  logic sign_reg;

  // Negation in WIDTH bits leaves -2^(WIDTH-1) as 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  assign a_mag  = Multiplicand[WIDTH-1] ? (~Multiplicand + WIDTH'(1)) : Multiplicand;
  assign b_mag  = Multiplier[WIDTH-1]   ? (~Multiplier + WIDTH'(1))   : Multiplier;
  assign result = sign_reg ? (~acc + (2*WIDTH)'(1)) : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_reg <= 1'b0;
    end else if (load) begin
      sign_reg <= Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1];
    end
  end
`else
  assign a_mag  = Multiplicand;
  assign b_mag  = Multiplier;
  assign result = acc;
`endif

  shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a         (a_reg),
    .b         (b_mag),
    .acc       (acc),
    .last_iter (last_iter)
  );

  // Outputs are registered: the DONE-state edge publishes Product and Done,
  // so the pulse is seen during the first IDLE cycle that follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      Product <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          Busy <= Start;
          if (Start) begin
            a_reg <= a_mag;
            state <= RUN;
          end
        end
        RUN: begin
          Busy <= 1'b1;
          if (last_iter) begin
            state <= DONE;
          end
        end
        DONE: begin
          Product <= result;
          Done    <= 1'b1;
          Busy    <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// tb/tb_seq_mult_core.sv - self-checking bench for seq_mult_core
module tb_seq_mult_core;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   ma = '0;
  logic [W-1:0]   mb = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  seq_mult_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .Start        (start),
    .Multiplicand (ma),
    .Multiplier   (mb),
    .Product      (product),
    .Busy         (busy),
    .Done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
`ifdef SIGNED_MULT_EN
    p = $signed(a) * $signed(b);
`else
    p = int'(a) * int'(b);
`endif
    return p[2*W-1:0];
  endfunction

  // One operation; disturb_at>0 re-pulses Start with other operands mid-RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int disturb_at, input string name);
    int n;
    bit seen;
    bit busy_ok;
    logic [2*W-1:0] prev;
    prev = product;
    @(negedge clk);
    start = 1'b1; ma = a; mb = b;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_rise"}, busy, 1);
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == disturb_at) begin
        start = 1'b1; ma = ~a; mb = b + 8'd7;
      end else if (n == disturb_at + 1) begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 0;
      if (done) seen = 1;
      else if (n == LAT - 1) check({name, "_hold_run"}, product, prev);
    end
    start = 1'b0;
    check({name, "_latency"}, n, LAT);
    check({name, "_busy_run"}, busy_ok, 1);
    check({name, "_product"}, product, exp);
    @(negedge clk);
    check({name, "_done_width"}, done, 0);
    check({name, "_hold_idle"}, product, exp);
    check({name, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    int last;
    int ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

`ifdef SIGNED_MULT_EN
    vecs[0] = '{8'hFD, 8'd5,   16'hFFF1};
    vecs[1] = '{8'h80, 8'h80,  16'h4000};
    vecs[2] = '{8'd127, 8'hFF, 16'hFF81};
    vecs[3] = '{8'd13, 8'd11,  16'd143};
    vecs[4] = '{8'h00, 8'hC8,  16'd0};
`else
    vecs[0] = '{8'd13, 8'd11,  16'd143};
    vecs[1] = '{8'd0, 8'd200,  16'd0};
    vecs[2] = '{8'd255, 8'd255, 16'd65025};
    vecs[3] = '{8'd1, 8'd255,  16'd255};
    vecs[4] = '{8'd128, 8'd2,  16'd256};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_product", product, 0);
    end

    // Table-driven vectors
    for (int i = 0; i < 5; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, -1, $sformatf("vec%0d", i));

    // Start re-pulsed and operands changed mid-RUN
    run_op(8'd13, 8'd11, 16'd143, 3, "disturb");

    // Randomised against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, model(ra, rb), -1, $sformatf("rand%0d", i));
    end

    // Start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; ma = 8'd3; mb = 8'd7;
    last = -1; ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        check("held_product", product, 16'd21);
        if (last < 0) check("held_first_lat", i, LAT);
        else check("held_gap", i - last, LAT + 1);
        last = i;
        ndone++;
      end
    end
    start = 1'b0;
    check("held_count", ndone, 4);

    // Reset mid-RUN aborts
    @(negedge clk);
    start = 1'b1; ma = 8'd5; mb = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
